// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline IR register control with stall/annul FSM and hazard watchdog
module pipe_ctrl #(
    parameter logic [31:0] NOP_IR    = 32'h83FFF800,
    parameter int          STALL_MAX = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ir_fetch,
    input  logic        stall_req,
    input  logic        branch_taken,
    output logic [31:0] ir_decode,
    output logic [31:0] ir_exec,
    output logic [31:0] ir_mem,
    output logic [31:0] ir_wb,
    output logic        fetch_hold,
    output logic        opcode_type_op,
    output logic        opcode_ld_ldr_exec,
    output logic        opcode_ld_ldr_mem,
    output logic        opcode_ld_ldr_wb,
    output logic        wb_we,
    output logic [4:0]  wb_wa,
    output logic [1:0]  state,
    output logic [15:0] stall_cnt,
    output logic [15:0] annul_cnt,
    output logic        hazard_err
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        ANNUL = 2'd2
    } state_t;

    localparam logic [15:0] RUN_MAX = 16'(STALL_MAX);

    state_t      state_q;
    logic [15:0] run_cnt;
    logic        do_annul;

    // A stall always wins; a branch seen during a stall is retried once it clears.
    assign do_annul = branch_taken & ~stall_req;

    function automatic logic is_ld_ldr(input logic [31:0] ir);
        return (ir[31:26] == 6'h18) || (ir[31:26] == 6'h1F);
    endfunction

    function automatic logic writes_reg(input logic [31:0] ir);
        logic [5:0] op;
        op = ir[31:26];
        return ((op[5:4] == 2'b10) || (op[5:4] == 2'b11) ||
                (op == 6'h18) || (op == 6'h1B) || (op == 6'h1C) ||
                (op == 6'h1D) || (op == 6'h1F)) && (ir[25:21] != 5'd31);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ir_decode  <= NOP_IR;
            ir_exec    <= NOP_IR;
            ir_mem     <= NOP_IR;
            ir_wb      <= NOP_IR;
            state_q    <= RUN;
            stall_cnt  <= 16'd0;
            annul_cnt  <= 16'd0;
            run_cnt    <= 16'd0;
            hazard_err <= 1'b0;
        end else begin
            ir_wb  <= ir_mem;
            ir_mem <= ir_exec;
            if (stall_req) begin
                ir_exec <= NOP_IR;
            end else if (do_annul) begin
                ir_exec   <= ir_decode;
                ir_decode <= NOP_IR;
            end else begin
                ir_exec   <= ir_decode;
                ir_decode <= ir_fetch;
            end

            if (stall_req && stall_cnt != 16'hFFFF)
                stall_cnt <= stall_cnt + 16'd1;
            if (do_annul && annul_cnt != 16'hFFFF)
                annul_cnt <= annul_cnt + 16'd1;

            if (!stall_req)
                run_cnt <= 16'd0;
            else if (run_cnt != RUN_MAX)
                run_cnt <= run_cnt + 16'd1;

            if (stall_req && run_cnt == RUN_MAX - 16'd1)
                hazard_err <= 1'b1;

            case (state_q)
                RUN, STALL: begin
                    if (stall_req)
                        state_q <= STALL;
                    else if (branch_taken)
                        state_q <= ANNUL;
                    else
                        state_q <= RUN;
                end
                ANNUL:   state_q <= stall_req ? STALL : RUN;
                default: state_q <= RUN;
            endcase
        end
    end

    assign state              = state_q;
    assign fetch_hold         = stall_req & ~rst;
    assign opcode_type_op     = (ir_decode[31:30] == 2'b10);
    assign opcode_ld_ldr_exec = is_ld_ldr(ir_exec);
    assign opcode_ld_ldr_mem  = is_ld_ldr(ir_mem);
    assign opcode_ld_ldr_wb   = is_ld_ldr(ir_wb);
    assign wb_we              = writes_reg(ir_wb) & ~rst;
    assign wb_wa              = ir_wb[25:21];

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter: NOP_IR, default 32'h83FFF800, meaning the instruction injected as a bubble, ADD(R31,R31,R31).
REQ-002 Parameter: STALL_MAX, default 8, meaning the number of consecutive stall cycles after which a hazard error is flagged.
REQ-003 Port: clk  in  1  single clock; all flops rise on posedge.
REQ-004 Port: rst  in  1  reset, asynchronous, active-high.
REQ-005 Port: ir_fetch  in  32  instruction from the fetch stage.
REQ-006 Port: stall_req  in  1  load-use stall request from the register file.
REQ-007 Port: branch_taken  in  1  branch/JMP resolved taken in decode.
REQ-008 Port: ir_decode, ir_exec, ir_mem, ir_wb  out  32 each  pipeline IR registers.
REQ-009 Port: fetch_hold  out  1  PC/fetch hold.
REQ-010 Port: opcode_type_op  out  1  decode opcode[31:30]==2'b10.
REQ-011 Port: opcode_ld_ldr_exec / _mem / _wb  out  1 each  stage opcode is LD (6'h18) or LDR (6'h1F).
REQ-012 Port: wb_we  out  1  register-file write enable.
REQ-013 Port: wb_wa  out  5  write address, ir_wb[25:21].
REQ-014 Port: state  out  2  FSM state: RUN=0, STALL=1, ANNUL=2.
REQ-015 Port: stall_cnt  out  16  total stall cycles, saturating.
REQ-016 Port: annul_cnt  out  16  total annulled instructions, saturating.
REQ-017 Port: hazard_err  out  1  sticky watchdog flag.

Function
REQ-018 Advance, with no stall and no branch: decode<=ir_fetch, exec<=decode, mem<=exec, wb<=mem, all in one cycle.
REQ-019 stall_req=1: decode held, exec<=NOP_IR, mem<=exec, wb<=mem; fetch_hold=1 combinationally in the same cycle.
REQ-020 branch_taken=1 with stall_req=0: exec<=decode, decode<=NOP_IR (fetched instruction annulled); annul_cnt increments.
REQ-021 Simultaneous stall_req and branch_taken: stall wins; the branch is ignored that cycle and re-evaluated when the stall clears.
REQ-022 FSM next state: RUN->STALL on stall_req; RUN->ANNUL on branch_taken & !stall_req; STALL->RUN when stall_req=0; STALL stays on stall_req; ANNUL->RUN, or ->STALL if stall_req; ANNUL lasts exactly one cycle without stall.
REQ-023 stall_cnt increments by 1 per cycle with stall_req=1; it saturates at 16'hFFFF with no wrap; annul_cnt saturates identically.
REQ-024 An internal run counter counts consecutive stall cycles and clears on any non-stall cycle.
REQ-025 hazard_err is set when the run counter reaches STALL_MAX and stays set until reset.
REQ-026 wb_we = (ir_wb[31:30]==2'b10 | ir_wb[31:30]==2'b11 | opcode in {18,1B,1C,1D,1F} hex) & ir_wb[25:21]!=5'd31; combinational.
REQ-027 ST (6'h19) and NOP_IR never assert wb_we.
REQ-028 opcode_* outputs are combinational decodes of the current stage registers.

Reset
REQ-029 rst=1 asynchronously sets all four IR registers to NOP_IR, state=RUN, both counters=0, the run counter=0, and hazard_err=0.
REQ-030 While rst=1, fetch_hold=0 and wb_we=0.
REQ-031 Reset mid-stall or mid-annul takes effect immediately; the first post-reset edge with stall_req=0 loads ir_fetch into decode.

Verification
REQ-032 Reset, then feed ADD R1,R2,R3 (0x80221800) for 4 cycles -> it appears in ir_wb on cycle 4, wb_we=1, wb_wa=1.
REQ-033 Hold stall_req=1 for 2 cycles with LD in exec -> ir_decode held, two NOP_IR bubbles enter exec, fetch_hold=1 on both cycles, stall_cnt=2.
REQ-034 branch_taken=1 for 1 cycle -> the next ir_decode=NOP_IR, annul_cnt=1, state sequence RUN,ANNUL,RUN.
REQ-035 stall_req and branch_taken both 1 -> state=STALL, annul_cnt unchanged; drop stall with branch still 1 -> state=ANNUL.
REQ-036 stall_req=1 for 8 cycles -> hazard_err=1 on cycle 8 and stays 1 after the stall clears; assert rst mid-run -> all outputs return to reset values without waiting for a clock edge.
REQ-037 Write to R31 (ADD R31,...) or ST reaching wb -> wb_we=0.
